result_display: RTL and testbench
=================================

# result_display

Result display driver for the 8-bit ALU output `O`. It captures an unsigned 8-bit result on a load strobe and converts it to three BCD digits with an iterative double-dabble sub-module. It then time-multiplexes the digits onto a common-anode 7-segment display with leading-zero blanking. It is the consumer of the ALU's registered output and sits between the ALU and the board's display pins.

## Interface
Parameters:
- `SCAN_DIV`, default 16: clock cycles each digit stays lit. Must be ≥ 2; boards use 100000, benches use 4.

Ports:
- `Clk`, input, 1: single clock; all state changes on the rising edge.
- `Rst`, input, 1: reset, asynchronous and active-low.
- `Din`, input, 8: unsigned value to display, normally the ALU `O`.
- `Load`, input, 1: capture `Din` and start a conversion; honoured only when idle.
- `Busy`, output, 1: high while a conversion is in progress.
- `Seg`, output, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `An`, output, 3: digit enables, active-low. `An[0]` is units, `An[1]` tens, `An[2]` hundreds.

## Operation
- FSM states:
  - IDLE: `Load`=1 latches `Din` into a shift register, clears the BCD accumulator and moves to SHIFT.
  - SHIFT: 8 iterations. Each iteration adds 3 to any BCD nibble ≥ 5, then shifts the combined register left by 1. After the 8th iteration the FSM moves to DONE.
  - DONE: copies the BCD digits into the display registers and returns to IDLE.
- `Busy` = (state ≠ IDLE).
- `Load` while busy (SHIFT or DONE) is ignored. It is not queued.
- `Din` is sampled only on the accepting edge; later changes do not affect the conversion in progress.
- Display registers hold the last completed value until the next DONE.
- Blanking:
  - The hundreds digit is blanked when it is 0.
  - The tens digit is blanked when both hundreds and tens are 0.
  - The units digit is always shown.
  - A blanked digit drives `Seg`=7'b1111111; its `An` bit still follows the scan.
- Scan:
  - A counter runs from 0 to SCAN_DIV−1.
  - On wrap, the digit index advances 0→1→2→0.
  - `An` is one-cold on the index; `Seg` carries the encoding of the selected digit.
  - The scan runs continuously and is independent of the FSM.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Value range is 0..255, so the hundreds digit never exceeds 2; no overflow is possible.

## Timing
- Reset values:
  - FSM = IDLE, `Busy`=0.
  - Display registers = 0, which shows "0" with tens and hundreds blanked.
  - Scan counter and index = 0, so `An`=3'b110 and `Seg`=7'b1000000.
- Conversion timing, with `Load` sampled at edge k:
  - `Busy` rises after edge k.
  - Shifts occur on edges k+1..k+8.
  - DONE occurs at edge k+9; the display registers update and `Busy` falls after that edge.
  - Total latency is 9 cycles. A new `Load` is accepted at edge k+10 at the earliest.
- Outputs are registered:
  - `An`/`Seg` change on the same edge the scan index advances.
  - A new display value appears on `Seg` at the next edge at which its digit is selected after k+9.
- Reset asserted mid-conversion aborts the conversion. Everything returns to reset values and the old display value is lost.
- `Load` on the DONE edge is ignored; it must be re-asserted in IDLE.

## Structure
- Package `display_pkg`:
  - FSM state enum (IDLE, SHIFT, DONE).
  - Digit count constant (3).
  - The 7-segment code constants.
  - The blank code 7'b1111111.
- Sub-module `bin2bcd8`:
  - Contains the FSM and the double-dabble datapath.
  - Ports: `Clk`, `Rst`, `Din`, `Load`, `Busy`, and three 4-bit digit outputs plus a one-cycle `Done` pulse.
- The top level holds the display registers, the blanking logic and the scan logic.

## Test plan
- Reset, then observe with SCAN_DIV=4:
  - `Busy`=0.
  - `An` sequence 110, 101, 011, repeating every 12 cycles.
  - `Seg` = 1000000, 1111111, 1111111 respectively.
- `Din`=8'd8, `Load` pulse: `Busy` is high for exactly 9 cycles, then units = 0000000 and tens/hundreds are blanked.
- `Din`=8'd255, `Load`: the digits show 2, 5, 5. Hundreds `Seg`=0100100; tens and units `Seg`=0010010.
- `Din`=8'd100, `Load`: hundreds shows 1111001; tens and units both show 1000000 (no blanking of the interior zero).
- `Load` with `Din`=8'd42, then `Load` again on the 3rd busy cycle with `Din`=8'd7: the display shows "42", `Busy` stays 9 cycles total, and the second load is ignored.
- Display "42", then start converting 8'd99 and assert `Rst` low on the 5th busy cycle: `Busy`=0 immediately and the display returns to "0".

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the result display driver:
//   - conversion FSM state encodings and enum
//   - number of display digits
//   - active-low 7-segment codes {g,f,e,d,c,b,a} and the blank code
//   - seg_encode(): BCD digit -> segment code
//   - dd_adjust():  double-dabble "add 3 if >= 5" step for one BCD nibble
// -----------------------------------------------------------------------------
package display_pkg;

    // Fixed state encodings so the FSM stays compatible with older netlists.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

    localparam int DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // A nibble >= 5 would become >= 10 after the next shift, so it is
    // pre-corrected by +3 to carry properly into the next BCD digit.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/result_display_if.sv
// -----------------------------------------------------------------------------
// result_display_if
// Bus between the ALU-side producer and the result display driver.
//   Din  : unsigned value to display (master -> slave)
//   Load : capture Din and start a conversion (master -> slave)
//   Busy : conversion in progress (slave -> master)
//   Seg  : active-low segments {g,f,e,d,c,b,a} (slave -> pins)
//   An   : active-low digit enables, An[0] = units (slave -> pins)
// -----------------------------------------------------------------------------
interface result_display_if;
    import display_pkg::*;

    logic [7:0]        Din;
    logic              Load;
    logic              Busy;
    logic [6:0]        Seg;
    logic [DIGITS-1:0] An;

    modport master (output Din, Load, input Busy, Seg, An);
    modport slave  (input Din, Load, output Busy, Seg, An);

endinterface

// File: rtl/bin2bcd8.sv
// -----------------------------------------------------------------------------
// bin2bcd8
// Iterative double-dabble converter: 8-bit unsigned binary -> 3 BCD digits.
// One shift per clock; 9 cycles from the accepting edge to the Done pulse.
// Ports:
//   Clk, Rst          : clock, asynchronous active-low reset
//   Din, Load         : value and start strobe (honoured only in IDLE)
//   Busy              : state != IDLE
//   Hund, Tens, Units : BCD digits, valid while Done is high
//   Done              : one-cycle pulse in the DONE state
// -----------------------------------------------------------------------------
module bin2bcd8
    import display_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Din,
    input  logic       Load,
    output logic       Busy,
    output logic [3:0] Hund,
    output logic [3:0] Tens,
    output logic [3:0] Units,
    output logic       Done
);

    state_e      r_state;
    // Combined shift register: {hundreds, tens, units, binary}.
    logic [19:0] r_sr;
    logic [2:0]  r_cnt;
    logic [11:0] w_adj;

    assign w_adj = {dd_adjust(r_sr[19:16]), dd_adjust(r_sr[15:12]), dd_adjust(r_sr[11:8])};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Load) begin
                        r_sr    <= {12'd0, Din};
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sr  <= {w_adj, r_sr[7:0]} << 1;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Busy  = (r_state != IDLE);
    assign Done  = (r_state == DONE);
    assign Hund  = r_sr[19:16];
    assign Tens  = r_sr[15:12];
    assign Units = r_sr[11:8];

endmodule

// File: rtl/result_display.sv
// -----------------------------------------------------------------------------
// result_display
// Captures an 8-bit ALU result, converts it to BCD and scans it onto a
// common-anode 3-digit 7-segment display with leading-zero blanking.
// Parameters:
//   SCAN_DIV : clock cycles each digit stays lit (>= 2)
// Ports:
//   Clk  : clock
//   Rst  : asynchronous active-low reset
//   bus  : slave side of result_display_if (Din, Load, Busy, Seg, An)
// -----------------------------------------------------------------------------
module result_display
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    result_display_if.slave   bus
);

    localparam int CW = $clog2(SCAN_DIV);

    logic              w_busy;
    logic              w_done;
    logic [3:0]        w_hund;
    logic [3:0]        w_tens;
    logic [3:0]        w_units;

    logic [3:0]        r_hund;
    logic [3:0]        r_tens;
    logic [3:0]        r_units;

    logic [CW-1:0]     r_scan_cnt;
    logic [1:0]        r_idx;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;

    logic              w_wrap;
    logic [1:0]        w_idx_nxt;
    logic              w_hund_blank;
    logic              w_tens_blank;
    logic [6:0]        w_seg_nxt;
    logic [DIGITS-1:0] w_an_nxt;

    bin2bcd8 u_conv (
        .Clk   (Clk),
        .Rst   (Rst),
        .Din   (bus.Din),
        .Load  (bus.Load),
        .Busy  (w_busy),
        .Hund  (w_hund),
        .Tens  (w_tens),
        .Units (w_units),
        .Done  (w_done)
    );

    // Display registers: hold the last completed conversion.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_hund  <= '0;
            r_tens  <= '0;
            r_units <= '0;
        end else if (w_done) begin
            r_hund  <= w_hund;
            r_tens  <= w_tens;
            r_units <= w_units;
        end
    end

    assign w_wrap       = (r_scan_cnt == CW'(SCAN_DIV - 1));
    assign w_idx_nxt    = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    assign w_hund_blank = (r_hund == 4'd0);
    assign w_tens_blank = w_hund_blank && (r_tens == 4'd0);
    assign w_an_nxt     = ~(DIGITS'(1) << w_idx_nxt);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        case (w_idx_nxt)
            2'd0:    w_seg_nxt = seg_encode(r_units);
            2'd1:    w_seg_nxt = w_tens_blank ? SEG_BLANK : seg_encode(r_tens);
            2'd2:    w_seg_nxt = w_hund_blank ? SEG_BLANK : seg_encode(r_hund);
            default: w_seg_nxt = SEG_BLANK;
        endcase
    end

    // Free-running scan. An/Seg are registered and reload only when the
    // digit index advances, so a new value shows at the next selection of
    // its digit. Reset state matches a display of "0" on the units digit.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
            r_an       <= 3'b110;
            r_seg      <= SEG_0;
        end else if (w_wrap) begin
            r_scan_cnt <= '0;
            r_idx      <= w_idx_nxt;
            r_an       <= w_an_nxt;
            r_seg      <= w_seg_nxt;
        end else begin
            r_scan_cnt <= r_scan_cnt + CW'(1);
        end
    end

    assign bus.Busy = w_busy;
    assign bus.Seg  = r_seg;
    assign bus.An   = r_an;

endmodule

// File: tb/tb_result_display.sv
// -----------------------------------------------------------------------------
// tb_result_display
// Self-checking bench for result_display with SCAN_DIV = 4.
// -----------------------------------------------------------------------------
module tb_result_display;

    localparam int SCAN_DIV = 4;
    localparam int PERIOD   = 3 * SCAN_DIV;

    // Independent copy of the segment table.
    localparam logic [6:0] C0 = 7'b1000000;
    localparam logic [6:0] C1 = 7'b1111001;
    localparam logic [6:0] C2 = 7'b0100100;
    localparam logic [6:0] C4 = 7'b0011001;
    localparam logic [6:0] C5 = 7'b0010010;
    localparam logic [6:0] C7 = 7'b1111000;
    localparam logic [6:0] C8 = 7'b0000000;
    localparam logic [6:0] C9 = 7'b0010000;
    localparam logic [6:0] CB = 7'b1111111;

    typedef struct packed {
        logic [6:0] h;
        logic [6:0] t;
        logic [6:0] u;
    } disp_t;

    typedef struct {
        logic [7:0] din;
        disp_t      exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    result_display_if u_if ();

    result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (u_if)
    );

    int    total = 0;
    int    bad   = 0;
    disp_t sb[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0b want=%0b", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Pulse Load for one edge and push the expected display to the scoreboard.
    // Returns at the first negedge after the accepting edge.
    task automatic start_load(input logic [7:0] d, input disp_t e);
        u_if.Din  = d;
        u_if.Load = 1'b1;
        sb.push_back(e);
        step();
        u_if.Load = 1'b0;
        u_if.Din  = ~d;
    endtask

    // Count negedges with Busy high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (u_if.Busy === 1'b1 && n < 50) begin
            n++;
            step();
        end
    endtask

    // Let every digit refresh, then record one full scan period.
    task automatic read_display(output disp_t got);
        got = 'x;
        repeat (PERIOD) step();
        for (int i = 0; i < PERIOD; i++) begin
            case (u_if.An)
                3'b110:  got.u = u_if.Seg;
                3'b101:  got.t = u_if.Seg;
                3'b011:  got.h = u_if.Seg;
                default: got   = 'x;
            endcase
            step();
        end
    endtask

    task automatic pop_compare(input string tag);
        disp_t got;
        disp_t e;
        read_display(got);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_hund"},  32'(got.h), 32'(e.h));
            check({tag, "_tens"},  32'(got.t), 32'(e.t));
            check({tag, "_units"}, 32'(got.u), 32'(e.u));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   n;

        vecs[0] = '{din: 8'd8,   exp: {CB, CB, C8}};
        vecs[1] = '{din: 8'd255, exp: {C2, C5, C5}};
        vecs[2] = '{din: 8'd100, exp: {C1, C0, C0}};
        vecs[3] = '{din: 8'd42,  exp: {CB, C4, C2}};
        vecs[4] = '{din: 8'd7,   exp: {CB, CB, C7}};
        vecs[5] = '{din: 8'd10,  exp: {CB, C1, C0}};
        vecs[6] = '{din: 8'd199, exp: {C1, C9, C9}};
        vecs[7] = '{din: 8'd0,   exp: {CB, CB, C0}};

        u_if.Din  = 8'd0;
        u_if.Load = 1'b0;
        repeat (3) step();
        check("rst_busy", 32'(u_if.Busy), 32'd0);
        rst_n = 1'b1;

        // Scan sequence from reset: 4 cycles per digit, units first.
        for (int i = 0; i < PERIOD; i++) begin
            logic [2:0] exp_an;
            exp_an = ~(3'b001 << (i / SCAN_DIV));
            check($sformatf("scan_an_%0d", i), 32'(u_if.An), 32'(exp_an));
            if (i == 0)            check("scan_seg_units", 32'(u_if.Seg), 32'(C0));
            if (i == SCAN_DIV)     check("scan_seg_tens",  32'(u_if.Seg), 32'(CB));
            if (i == 2 * SCAN_DIV) check("scan_seg_hund",  32'(u_if.Seg), 32'(CB));
            step();
        end
        check("idle_busy", 32'(u_if.Busy), 32'd0);

        for (int v = 0; v < 8; v++) begin
            start_load(vecs[v].din, vecs[v].exp);
            count_busy(n);
            check($sformatf("busy_cycles_%0d", vecs[v].din), 32'(n), 32'd9);
            pop_compare($sformatf("disp_%0d", vecs[v].din));
        end

        // Load 42, then a second Load (Din=7) on the 3rd busy cycle is ignored.
        start_load(8'd42, {CB, C4, C2});
        step();
        step();
        u_if.Din  = 8'd7;
        u_if.Load = 1'b1;
        step();
        u_if.Load = 1'b0;
        count_busy(n);
        check("busy_cycles_ignored_load", 32'(n + 3), 32'd9);
        repeat (3) step();
        check("no_queued_load", 32'(u_if.Busy), 32'd0);
        pop_compare("disp_42_ignore");

        // Reset on the 5th busy cycle of a conversion of 99.
        u_if.Din  = 8'd99;
        u_if.Load = 1'b1;
        step();
        u_if.Load = 1'b0;
        repeat (4) step();
        check("busy_before_abort", 32'(u_if.Busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(u_if.Busy), 32'd0);
        check("abort_an",   32'(u_if.An),   32'(3'b110));
        check("abort_seg",  32'(u_if.Seg),  32'(C0));
        step();
        rst_n = 1'b1;
        sb.push_back({CB, CB, C0});
        pop_compare("disp_after_abort");
        check("busy_after_abort", 32'(u_if.Busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
